// File: rtl/sl_pkg.sv
// Shared definitions for the serial-line word transmitter: config/status
// field positions, FSM encoding and the frame-building helper.
package sl_pkg;

    localparam int CFG_PCE  = 0;
    localparam int CFG_BQL  = 1;
    localparam int CFG_BQH  = 6;
    localparam int CFG_MODE = 7;
    localparam int CFG_IRQM = 8;

    localparam logic [15:0] CONFIG_RESET = 16'h0010;

    localparam int ST_TXB = 1;
    localparam int ST_BUF = 2;
    localparam int ST_TXD = 3;
    localparam int ST_OVF = 5;

    localparam int BQ_MIN = 8;
    localparam int BQ_MAX = 32;

    typedef enum logic [2:0] {
        IDLE,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        STOP_HIGH
    } tx_state_t;

    function automatic logic bq_valid(input logic [5:0] bq);
        return !bq[0] && (bq >= 6'(BQ_MIN)) && (bq <= 6'(BQ_MAX));
    endfunction

    // Data masked to bq bits with the odd-parity bit placed at position bq,
    // so after bq right-shifts the parity bit sits in bit 0.
    function automatic logic [32:0] build_frame(input logic [31:0] data,
                                                input logic [5:0]  bq);
        logic [32:0] mask;
        logic [32:0] masked;
        mask   = (33'd1 << bq) - 33'd1;
        masked = {1'b0, data} & mask;
        return masked | (33'(~^masked) << bq);
    endfunction

endpackage

// File: rtl/sl_tx_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so a
// load of N-1 yields a phase of exactly N cycles.
module sl_tx_phase_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/sl_transmitter.sv
// SL word transmitter: serialises BQ data bits LSB first, a parity symbol and
// a stop symbol onto the two-wire bus, with a one-word holding buffer.
module sl_transmitter
    import sl_pkg::*;
#(
    parameter int STATUS_WIDTH = 16,
    parameter int CONFIG_WIDTH = 16,
    parameter int LOW_CYCLES   = 8,
    parameter int HIGH_CYCLES  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             data_in,
    input  logic                    wr_data,
    input  logic [CONFIG_WIDTH-1:0] wr_config_w,
    input  logic                    wr_enable,
    output logic                    serial_line_zeroes_o,
    output logic                    serial_line_ones_o,
    output logic [STATUS_WIDTH-1:0] status_w,
    output logic [CONFIG_WIDTH-1:0] r_config_w,
    output logic                    data_status_changed
);

    localparam int PHASE_MAX = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int CNT_W     = $clog2(PHASE_MAX);

    tx_state_t   state;
    logic [32:0] shift_reg;
    logic [5:0]  bit_cnt;
    logic [5:0]  bq_lat;
    logic        buf_full;
    logic [31:0] buf_data;
    logic        busy;
    logic        txd;
    logic        ovf;

    logic             phase_done;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             start_idle;
    logic             finish;
    logic             start;
    logic             cfg_ok;
    logic [5:0]       cfg_bq;
    logic [31:0]      next_word;
    logic [32:0]      next_frame;

    assign cfg_bq     = r_config_w[CFG_BQH:CFG_BQL];
    assign start_idle = (state == IDLE) && wr_data;
    assign finish     = (state == STOP_HIGH) && phase_done;
    assign start      = start_idle || (finish && (buf_full || wr_data));
    assign cfg_ok     = wr_enable && (state == IDLE) && !buf_full && !wr_data &&
                        bq_valid(wr_config_w[CFG_BQH:CFG_BQL]);
    assign next_word  = (state == STOP_HIGH && buf_full) ? buf_data : data_in;
    assign next_frame = build_frame(next_word, cfg_bq);

    // Timer reloads on every phase entry; a low phase is always followed by a high one.
    assign timer_load = start_idle || ((state != IDLE) && phase_done);
    assign timer_val  = (state == BIT_LOW || state == STOP_LOW) ?
                        CNT_W'(HIGH_CYCLES - 1) : CNT_W'(LOW_CYCLES - 1);

    sl_tx_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (phase_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            shift_reg            <= '0;
            bit_cnt              <= '0;
            bq_lat               <= '0;
            buf_full             <= 1'b0;
            // NOTE: buf_data is a single word, not a memory, so resetting it is
            // cheap and guarantees a reset flushes any stale buffered data.
            buf_data             <= '0;
            busy                 <= 1'b0;
            txd                  <= 1'b0;
            ovf                  <= 1'b0;
            serial_line_zeroes_o <= 1'b1;
            serial_line_ones_o   <= 1'b1;
            data_status_changed  <= 1'b0;
            r_config_w           <= CONFIG_WIDTH'(CONFIG_RESET);
        end else begin
            data_status_changed <= 1'b0;

            if (cfg_ok) begin
                r_config_w <= wr_config_w;
            end

            // A finishing frame frees the buffer slot in the same cycle.
            if (finish) begin
                if (buf_full) begin
                    if (wr_data) begin
                        buf_data <= data_in;
                        ovf      <= 1'b0;
                    end else begin
                        buf_full <= 1'b0;
                    end
                end else if (wr_data) begin
                    ovf <= 1'b0;
                end
            end else if (wr_data && state != IDLE) begin
                if (!buf_full) begin
                    buf_data <= data_in;
                    buf_full <= 1'b1;
                    ovf      <= 1'b0;
                end else begin
                    ovf                 <= 1'b1;
                    data_status_changed <= 1'b1;
                end
            end else if (start_idle) begin
                ovf <= 1'b0;
            end

            case (state)
                BIT_LOW: begin
                    if (phase_done) begin
                        state                <= BIT_HIGH;
                        serial_line_zeroes_o <= 1'b1;
                        serial_line_ones_o   <= 1'b1;
                    end
                end
                BIT_HIGH: begin
                    if (phase_done) begin
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == bq_lat) begin
                            state                <= STOP_LOW;
                            serial_line_zeroes_o <= 1'b0;
                            serial_line_ones_o   <= 1'b0;
                        end else begin
                            state                <= BIT_LOW;
                            serial_line_zeroes_o <= shift_reg[1];
                            serial_line_ones_o   <= ~shift_reg[1];
                        end
                    end
                end
                STOP_LOW: begin
                    if (phase_done) begin
                        state                <= STOP_HIGH;
                        serial_line_zeroes_o <= 1'b1;
                        serial_line_ones_o   <= 1'b1;
                    end
                end
                STOP_HIGH: begin
                    if (phase_done) begin
                        txd                 <= 1'b1;
                        data_status_changed <= 1'b1;
                        state               <= IDLE;
                        busy                <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Frame start overrides the case above (idle start or zero-gap restart).
            if (start) begin
                state                <= BIT_LOW;
                busy                 <= 1'b1;
                shift_reg            <= next_frame;
                bit_cnt              <= '0;
                bq_lat               <= cfg_bq;
                serial_line_zeroes_o <= next_frame[0];
                serial_line_ones_o   <= ~next_frame[0];
                if (start_idle) begin
                    txd <= 1'b0;
                end
            end
        end
    end

    // NOTE: every bit gets a default first so this block can never infer a latch.
    always_comb begin
        status_w         = '0;
        status_w[ST_TXB] = busy;
        status_w[ST_BUF] = buf_full;
        status_w[ST_TXD] = txd;
        status_w[ST_OVF] = ovf;
    end

endmodule
